branch_predictor_unit: RTL and testbench

//  Parametrised dynamic branch predictor for the 5-stage RISC-V pipeline; successor to the no-prediction baseline.

---
 rtl/bp_pkg.sv | 28 ++
 rtl/branch_predictor_unit_if.sv | 28 ++
 rtl/bp_sat_counter_array.sv | 47 ++++
 rtl/branch_predictor_unit.sv | 120 ++++++++++++
 tb/tb_branch_predictor_unit.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared constants and saturating-arithmetic helpers for the branch predictor.
package bp_pkg;

    localparam int unsigned MODE_STATIC  = 0;
    localparam int unsigned MODE_BIMODAL = 1;
    localparam int unsigned MODE_GSHARE  = 2;

    localparam int unsigned ADDR_W = 30;

    // All-ones value of a w-bit counter, carried in 32 bits (w <= 32).
    function automatic logic [31:0] width_max(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Weakly-not-taken starting point: just below the taken threshold.
    function automatic logic [31:0] cnt_init(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        return (v == width_max(w)) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? v : v - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_unit_if.sv
// Fetch-side lookup and decode-side training bundle for the branch predictor.
interface branch_predictor_unit_if #(
    parameter int unsigned PERF_W = 32
);
    logic              memory_stall;
    logic [29:0]       lookup_addr;
    logic              predict_taken;
    logic [29:0]       predict_target;
    logic              upd_valid;
    logic [29:0]       upd_addr;
    logic              upd_taken;
    logic [29:0]       upd_target;
    logic              upd_mispredict;
    logic [PERF_W-1:0] perf_branches;
    logic [PERF_W-1:0] perf_mispred;

    modport master (
        output memory_stall, lookup_addr, upd_valid, upd_addr, upd_taken, upd_target,
               upd_mispredict,
        input  predict_taken, predict_target, perf_branches, perf_mispred
    );

    modport slave (
        input  memory_stall, lookup_addr, upd_valid, upd_addr, upd_taken, upd_target,
               upd_mispredict,
        output predict_taken, predict_target, perf_branches, perf_mispred
    );
endinterface

// File: rtl/bp_sat_counter_array.sv
// Table of saturating counters: one combinational read port, one read-modify-write port.
module bp_sat_counter_array
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [CNT_W-1:0] rd_cnt_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);
    localparam int unsigned Entries = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] CntInit = CNT_W'(cnt_init(CNT_W));

    logic [CNT_W-1:0] cnt_q [Entries];
    logic [CNT_W-1:0] cnt_d [Entries];
    logic [CNT_W-1:0] wr_cur;
    logic [CNT_W-1:0] wr_nxt;

    always_comb begin
        wr_cur = cnt_q[wr_idx_i];
        wr_nxt = wr_taken_i ? CNT_W'(sat_inc(32'(wr_cur), CNT_W))
                            : CNT_W'(sat_dec(32'(wr_cur)));
        cnt_d  = cnt_q;
        if (wr_en_i) begin
            cnt_d[wr_idx_i] = wr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Entries; i++) begin
                cnt_q[i] <= CntInit;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // No write-to-read bypass: a same-cycle lookup sees the pre-update count.
    assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/branch_predictor_unit.sv
// Dynamic branch predictor: BHT of saturating counters, tagged BTB, global history and
// benchmarking counters. Lookup is combinational; training comes from resolved branches.
module branch_predictor_unit
    import bp_pkg::*;
#(
    parameter int unsigned MODE   = MODE_GSHARE,
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned CNT_W  = 2,
    parameter int unsigned GHR_W  = 6,
    parameter int unsigned PERF_W = 32
) (
    input logic                    clk,
    input logic                    rst_n,
    branch_predictor_unit_if.slave bp
);
    localparam int unsigned Entries = 2 ** IDX_W;
    localparam int unsigned TagW    = ADDR_W - IDX_W;

    logic              accept;
    logic              train;
    logic [IDX_W-1:0]  hist;
    logic [IDX_W-1:0]  lk_btb_idx;
    logic [IDX_W-1:0]  lk_bht_idx;
    logic [IDX_W-1:0]  up_btb_idx;
    logic [IDX_W-1:0]  up_bht_idx;
    logic [CNT_W-1:0]  lk_cnt;
    logic              lk_hit;

    logic [GHR_W-1:0]  ghr_q, ghr_d;
    logic              btb_valid_q  [Entries];
    logic              btb_valid_d  [Entries];
    logic [TagW-1:0]   btb_tag_q    [Entries];
    logic [TagW-1:0]   btb_tag_d    [Entries];
    logic [ADDR_W-1:0] btb_target_q [Entries];
    logic [ADDR_W-1:0] btb_target_d [Entries];
    logic [PERF_W-1:0] perf_br_q, perf_br_d;
    logic [PERF_W-1:0] perf_mis_q, perf_mis_d;

    // A stalled decode holds its branch, so only the unstalled cycle trains.
    assign accept = bp.upd_valid && !bp.memory_stall;
    assign train  = accept && (MODE != MODE_STATIC);

    always_comb begin
        hist       = IDX_W'(ghr_q);
        lk_btb_idx = bp.lookup_addr[IDX_W-1:0];
        up_btb_idx = bp.upd_addr[IDX_W-1:0];
        lk_bht_idx = (MODE == MODE_GSHARE) ? (lk_btb_idx ^ hist) : lk_btb_idx;
        up_bht_idx = (MODE == MODE_GSHARE) ? (up_btb_idx ^ hist) : up_btb_idx;
    end

    bp_sat_counter_array #(
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_bht (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (lk_bht_idx),
        .rd_cnt_o   (lk_cnt),
        .wr_en_i    (train),
        .wr_idx_i   (up_bht_idx),
        .wr_taken_i (bp.upd_taken)
    );

    always_comb begin
        lk_hit = btb_valid_q[lk_btb_idx] &&
                 (btb_tag_q[lk_btb_idx] == bp.lookup_addr[ADDR_W-1:IDX_W]);
        bp.predict_taken  = (MODE != MODE_STATIC) && lk_hit && lk_cnt[CNT_W-1];
        bp.predict_target = lk_hit ? btb_target_q[lk_btb_idx] : '0;
    end

    always_comb begin
        btb_valid_d  = btb_valid_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;
        ghr_d        = ghr_q;
        if (train && bp.upd_taken) begin
            btb_valid_d[up_btb_idx]  = 1'b1;
            btb_tag_d[up_btb_idx]    = bp.upd_addr[ADDR_W-1:IDX_W];
            btb_target_d[up_btb_idx] = bp.upd_target;
        end
        if (train && (MODE == MODE_GSHARE)) begin
            ghr_d = GHR_W'({ghr_q, bp.upd_taken});
        end
    end

    always_comb begin
        perf_br_d  = perf_br_q;
        perf_mis_d = perf_mis_q;
        if (accept) begin
            perf_br_d = PERF_W'(sat_inc(32'(perf_br_q), PERF_W));
            if (bp.upd_mispredict) begin
                perf_mis_d = PERF_W'(sat_inc(32'(perf_mis_q), PERF_W));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q      <= '0;
            perf_br_q  <= '0;
            perf_mis_q <= '0;
            for (int i = 0; i < Entries; i++) begin
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
            end
        end else begin
            ghr_q        <= ghr_d;
            perf_br_q    <= perf_br_d;
            perf_mis_q   <= perf_mis_d;
            btb_valid_q  <= btb_valid_d;
            btb_tag_q    <= btb_tag_d;
            btb_target_q <= btb_target_d;
        end
    end

    assign bp.perf_branches = perf_br_q;
    assign bp.perf_mispred  = perf_mis_q;

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Three predictors (bimodal, gshare, static with 4-bit perf counters) fed one branch stream
// and checked every cycle against a table-level model of prediction and training.
module tb_branch_predictor_unit;
    import bp_pkg::*;

    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        stall, uvalid, utaken;
    logic [29:0] uaddr, utarget, laddr;
    logic        mis [ND];

    branch_predictor_unit_if #(.PERF_W(32)) if0 ();
    branch_predictor_unit_if #(.PERF_W(32)) if1 ();
    branch_predictor_unit_if #(.PERF_W(4))  if2 ();

    assign if0.memory_stall = stall;   assign if1.memory_stall = stall;
    assign if2.memory_stall = stall;
    assign if0.lookup_addr  = laddr;   assign if1.lookup_addr  = laddr;
    assign if2.lookup_addr  = laddr;
    assign if0.upd_valid    = uvalid;  assign if1.upd_valid    = uvalid;
    assign if2.upd_valid    = uvalid;
    assign if0.upd_addr     = uaddr;   assign if1.upd_addr     = uaddr;
    assign if2.upd_addr     = uaddr;
    assign if0.upd_taken    = utaken;  assign if1.upd_taken    = utaken;
    assign if2.upd_taken    = utaken;
    assign if0.upd_target   = utarget; assign if1.upd_target   = utarget;
    assign if2.upd_target   = utarget;
    assign if0.upd_mispredict = mis[0];
    assign if1.upd_mispredict = mis[1];
    assign if2.upd_mispredict = mis[2];

    branch_predictor_unit #(.MODE(1), .IDX_W(6), .CNT_W(2), .GHR_W(6), .PERF_W(32)) u_dut_bim (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (if0)
    );
    branch_predictor_unit #(.MODE(2), .IDX_W(6), .CNT_W(2), .GHR_W(6), .PERF_W(32)) u_dut_gsh (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (if1)
    );
    branch_predictor_unit #(.MODE(0), .IDX_W(6), .CNT_W(2), .GHR_W(6), .PERF_W(4)) u_dut_sta (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (if2)
    );

    logic        act_pt [ND];
    logic [29:0] act_tg [ND];
    logic [31:0] act_pb [ND];
    logic [31:0] act_pm [ND];
    assign act_pt[0] = if0.predict_taken;  assign act_tg[0] = if0.predict_target;
    assign act_pt[1] = if1.predict_taken;  assign act_tg[1] = if1.predict_target;
    assign act_pt[2] = if2.predict_taken;  assign act_tg[2] = if2.predict_target;
    assign act_pb[0] = if0.perf_branches;  assign act_pm[0] = if0.perf_mispred;
    assign act_pb[1] = if1.perf_branches;  assign act_pm[1] = if1.perf_mispred;
    assign act_pb[2] = 32'(if2.perf_branches);
    assign act_pm[2] = 32'(if2.perf_mispred);

    // Model: 64-entry tables, counters 0..3 (taken when >= 2), history as an integer.
    int          mode_of [ND] = '{1, 2, 0};
    logic [31:0] pmax    [ND] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd15};
    int          m_cnt [ND][64];
    bit          m_val [ND][64];
    int unsigned m_tag [ND][64];
    int unsigned m_tgt [ND][64];
    int          m_ghr [ND];
    logic [31:0] m_pb  [ND];
    logic [31:0] m_pm  [ND];

    function automatic int bht_index(input int d, input int unsigned a);
        int i;
        i = int'(a % 64);
        if (mode_of[d] == 2) i = i ^ m_ghr[d];
        return i;
    endfunction

    function automatic void model_predict(input int d, input int unsigned a,
                                          output bit tk, output int unsigned tg);
        int b;
        bit hit;
        b   = int'(a % 64);
        hit = m_val[d][b] && (m_tag[d][b] == a / 64);
        tg  = hit ? m_tgt[d][b] : 0;
        tk  = (mode_of[d] != 0) && hit && (m_cnt[d][bht_index(d, a)] >= 2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < ND; d++) begin
                m_ghr[d] = 0; m_pb[d] = 0; m_pm[d] = 0;
                for (int i = 0; i < 64; i++) begin
                    m_cnt[d][i] = 1; m_val[d][i] = 0; m_tag[d][i] = 0; m_tgt[d][i] = 0;
                end
            end
        end else if (uvalid && !stall) begin
            for (int d = 0; d < ND; d++) begin
                if (mode_of[d] != 0) begin
                    int k;
                    k = bht_index(d, uaddr);
                    if (utaken) m_cnt[d][k] = (m_cnt[d][k] == 3) ? 3 : m_cnt[d][k] + 1;
                    else        m_cnt[d][k] = (m_cnt[d][k] == 0) ? 0 : m_cnt[d][k] - 1;
                    if (utaken) begin
                        m_val[d][uaddr % 64] = 1;
                        m_tag[d][uaddr % 64] = uaddr / 64;
                        m_tgt[d][uaddr % 64] = utarget;
                    end
                    if (mode_of[d] == 2) m_ghr[d] = (m_ghr[d] * 2 + int'(utaken)) % 64;
                end
                if (m_pb[d] != pmax[d]) m_pb[d] = m_pb[d] + 1;
                if (mis[d] && m_pm[d] != pmax[d]) m_pm[d] = m_pm[d] + 1;
            end
        end
    end

    int    checks = 0;
    int    errors = 0;
    bit    cmp_en = 0;
    bit    lit_req = 0;
    int    lit_d, lit_kind;
    logic [31:0] lit_exp;
    string lit_name;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < ND; d++) begin
                bit          etk;
                int unsigned etg;
                model_predict(d, laddr, etk, etg);
                check($sformatf("d%0d_taken", d), 32'(act_pt[d]), 32'(etk));
                check($sformatf("d%0d_target", d), 32'(act_tg[d]), etg);
                check($sformatf("d%0d_perf_branches", d), act_pb[d], m_pb[d]);
                check($sformatf("d%0d_perf_mispred", d), act_pm[d], m_pm[d]);
            end
            if (lit_req) begin
                case (lit_kind)
                    0:       check(lit_name, 32'(act_pt[lit_d]), lit_exp);
                    1:       check(lit_name, 32'(act_tg[lit_d]), lit_exp);
                    2:       check(lit_name, act_pb[lit_d], lit_exp);
                    default: check(lit_name, act_pm[lit_d], lit_exp);
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mis();
        for (int d = 0; d < ND; d++) begin
            bit          tk;
            int unsigned tg;
            model_predict(d, uaddr, tk, tg);
            mis[d] = (tk != utaken);
        end
    endtask

    task automatic upd(input logic [29:0] a, input logic t, input logic [29:0] tg);
        uaddr = a; utaken = t; utarget = tg; uvalid = 1'b1;
        set_mis();
        step();
        uvalid = 1'b0;
    endtask

    task automatic lit(input int d, input int kind, input logic [31:0] exp, input string name);
        lit_d = d; lit_kind = kind; lit_exp = exp; lit_name = name; lit_req = 1'b1;
        @(negedge clk);
        #1;
        lit_req = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        stall = 0; uvalid = 0; utaken = 0; uaddr = '0; utarget = '0; laddr = '0;
        for (int d = 0; d < ND; d++) mis[d] = 0;
        step();
        cmp_en = 1;
        lit(0, 0, 0, "reset_taken");
        lit(2, 2, 0, "reset_perf_branches");
        step();
        rst_n = 1'b1;

        // Bimodal training at 0x40
        laddr = 30'h40;
        repeat (2) upd(30'h40, 1'b1, 30'h80);
        lit(0, 0, 1, "bim_taken_after_2T");
        lit(0, 1, 32'h80, "bim_target_after_2T");
        repeat (2) upd(30'h40, 1'b0, 30'h80);
        lit(0, 0, 0, "bim_not_taken_after_2N");
        repeat (5) upd(30'h40, 1'b0, 30'h80);
        lit(0, 0, 0, "bim_floor_after_5N");

        // Same index, different tag
        repeat (2) upd(30'h40, 1'b1, 30'h80);
        laddr = 30'h80040;
        lit(0, 0, 0, "alias_taken");
        lit(0, 1, 0, "alias_target");
        laddr = 30'h40;
        lit(0, 0, 1, "alias_own_taken");

        // Asynchronous reset mid-cycle with the BTB populated
        #2 rst_n = 1'b0;
        lit(0, 0, 0, "midrun_reset_taken");
        lit(0, 1, 0, "midrun_reset_target");
        lit(0, 2, 0, "midrun_reset_perf_branches");
        step();
        rst_n = 1'b1;

        // Stalled update trains exactly once
        uaddr = 30'h10; utaken = 1'b1; utarget = 30'h20; uvalid = 1'b1; stall = 1'b1;
        set_mis();
        repeat (3) step();
        stall = 1'b0;
        step();
        uvalid = 1'b0;
        lit(0, 2, 1, "stall_perf_branches");
        lit(2, 2, 1, "stall_perf_branches_static");

        // Alternating T/N stream: gshare learns it, bimodal does not
        pulse_reset();
        laddr = 30'h100;
        for (int i = 0; i < 10; i++) upd(30'h100, (i % 2) == 0, 30'h200);
        lit(1, 3, 4, "gshare_mispred_10");
        for (int i = 10; i < 20; i++) upd(30'h100, (i % 2) == 0, 30'h200);
        lit(1, 3, 4, "gshare_mispred_20");
        lit(0, 3, 20, "bimodal_mispred_20");
        lit(2, 3, 10, "static_mispred_20");
        lit(2, 2, 15, "static_branches_sat");

        // 4-bit perf counters saturate at 15
        pulse_reset();
        laddr = 30'h300;
        repeat (20) upd(30'h300, 1'b1, 30'h300);
        lit(2, 3, 15, "perf_mispred_sat");
        lit(2, 2, 15, "perf_branches_sat");
        lit(0, 2, 20, "perf_branches_wide");

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
